// File: rtl/branch_predictor_gshare_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_gshare_if
// Brief    : Fetch lookup, execute resolve and statistics bundle for the
//            gshare branch predictor.
// Revision : 1.0
// ============================================================================
interface branch_predictor_gshare_if #(
    parameter int STAT_W = 32
) ();
    logic [1:0]        mode;
    logic              clr;
    logic              lkp_valid;
    logic [31:0]       lkp_pc;
    logic              lkp_taken;
    logic              rslv_valid;
    logic [31:0]       rslv_pc;
    logic              rslv_taken;
    logic              busy;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_hits;
    logic [STAT_W-1:0] stat_st_hits;

    modport master (
        output mode, clr, lkp_valid, lkp_pc, rslv_valid, rslv_pc, rslv_taken,
        input  lkp_taken, busy, stat_branches, stat_hits, stat_st_hits
    );

    modport slave (
        input  mode, clr, lkp_valid, lkp_pc, rslv_valid, rslv_pc, rslv_taken,
        output lkp_taken, busy, stat_branches, stat_hits, stat_st_hits
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_gshare
// Brief    : Static-taken / bimodal / gshare predictor with PHT init sweep,
//            global history and saturating accuracy statistics.
// Revision : 1.0
// ============================================================================
module branch_predictor_gshare #(
    parameter int IDX_W    = 6,
    parameter int CTR_W    = 2,
    parameter int GHR_W    = 6,
    parameter int CTR_INIT = 1,
    parameter int STAT_W   = 32
) (
    input logic                     clk,
    input logic                     rst,
    branch_predictor_gshare_if.slave bus
);
    localparam int               c_DEPTH    = 1 << IDX_W;
    localparam logic [CTR_W-1:0] c_CTR_INIT = CTR_W'(CTR_INIT);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_init_idx;
    logic [CTR_W-1:0]    r_pht [0:c_DEPTH-1];
    logic [GHR_W-1:0]    r_ghr;
    logic [GHR_W-1:0]    w_ghr_nxt;
    logic [IDX_W-1:0]    w_ghr_ext;
    logic                r_lkp_taken;
    logic [STAT_W-1:0]   r_stat_branches;
    logic [STAT_W-1:0]   r_stat_hits;
    logic [STAT_W-1:0]   r_stat_st_hits;

    logic                w_run;
    logic                w_static;
    logic                w_rslv_en;
    logic [IDX_W-1:0]    w_lkp_idx;
    logic [IDX_W-1:0]    w_rslv_idx;
    logic                w_lkp_pred;
    logic                w_rslv_pred;
    logic [CTR_W-1:0]    w_rslv_ctr;
    logic [CTR_W-1:0]    w_ctr_upd;
    logic                w_unused_pc;

    // Static mode uses mode[1]=0, so it trains on the bimodal index.
    function automatic logic [IDX_W-1:0] f_index(input logic [31:0]      pc,
                                                 input logic             gshare,
                                                 input logic [IDX_W-1:0] ghr_ext);
        f_index = pc[IDX_W+1:2] ^ (gshare ? ghr_ext : '0);
    endfunction

    assign w_run       = (r_state == ST_RUN);
    assign w_static    = (bus.mode == 2'd0);
    assign w_rslv_en   = w_run & bus.rslv_valid & ~bus.clr;
    assign w_lkp_idx   = f_index(bus.lkp_pc,  bus.mode[1], w_ghr_ext);
    assign w_rslv_idx  = f_index(bus.rslv_pc, bus.mode[1], w_ghr_ext);
    assign w_rslv_ctr  = r_pht[w_rslv_idx];
    assign w_lkp_pred  = w_static | r_pht[w_lkp_idx][CTR_W-1];
    assign w_rslv_pred = w_static | w_rslv_ctr[CTR_W-1];
    assign w_unused_pc = ^{bus.lkp_pc[31:IDX_W+2], bus.lkp_pc[1:0],
                           bus.rslv_pc[31:IDX_W+2], bus.rslv_pc[1:0]};

    always_comb begin
        w_ghr_ext            = '0;
        w_ghr_ext[GHR_W-1:0] = r_ghr;
    end

    generate
        if (GHR_W == 1) begin : g_ghr_one
            assign w_ghr_nxt = bus.rslv_taken;
        end else begin : g_ghr_shift
            assign w_ghr_nxt = {r_ghr[GHR_W-2:0], bus.rslv_taken};
        end
    endgenerate

    always_comb begin
        w_ctr_upd = w_rslv_ctr;
        if (bus.rslv_taken && (w_rslv_ctr != '1)) begin
            w_ctr_upd = w_rslv_ctr + CTR_W'(1);
        end else if (!bus.rslv_taken && (w_rslv_ctr != '0)) begin
            w_ctr_upd = w_rslv_ctr - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (!bus.clr && (r_init_idx == '1)) w_state_nxt = ST_RUN;
            ST_RUN:  if (bus.clr)                        w_state_nxt = ST_INIT;
            default:                                     w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_idx <= '0;
        end else if (bus.clr || w_run) begin
            r_init_idx <= '0;
        end else begin
            r_init_idx <= r_init_idx + IDX_W'(1);
        end
    end

    // Table contents are fully defined by the init sweep, so no reset here.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_pht[r_init_idx] <= c_CTR_INIT;
        end else if (w_rslv_en) begin
            r_pht[w_rslv_idx] <= w_ctr_upd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lkp_taken     <= 1'b0;
            r_ghr           <= '0;
            r_stat_branches <= '0;
            r_stat_hits     <= '0;
            r_stat_st_hits  <= '0;
        end else begin
            r_lkp_taken <= w_run & bus.lkp_valid & w_lkp_pred;
            if (bus.clr) begin
                r_ghr           <= '0;
                r_stat_branches <= '0;
                r_stat_hits     <= '0;
                r_stat_st_hits  <= '0;
            end else if (w_rslv_en) begin
                r_ghr <= w_ghr_nxt;
                if (r_stat_branches != '1) begin
                    r_stat_branches <= r_stat_branches + STAT_W'(1);
                end
                if ((w_rslv_pred == bus.rslv_taken) && (r_stat_hits != '1)) begin
                    r_stat_hits <= r_stat_hits + STAT_W'(1);
                end
                if (bus.rslv_taken && (r_stat_st_hits != '1)) begin
                    r_stat_st_hits <= r_stat_st_hits + STAT_W'(1);
                end
            end
        end
    end

    assign bus.lkp_taken     = r_lkp_taken;
    assign bus.busy          = (r_state == ST_INIT);
    assign bus.stat_branches = r_stat_branches;
    assign bus.stat_hits     = r_stat_hits;
    assign bus.stat_st_hits  = r_stat_st_hits;
endmodule
`default_nettype wire
